// File: rtl/aes_round_sequencer.sv
// Control sequencer for an iterative AES core: key expansion, state load,
// NR cipher or inverse-cipher rounds, then a one-cycle done pulse.
module aes_round_sequencer #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    input  logic       key_reuse,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       keys_valid,
    output logic       kex_en,
    output logic [5:0] kex_word,
    output logic       ld_state,
    output logic       rnd_en,
    output logic [3:0] rk_idx,
    output logic       last_rnd,
    output logic       dec,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] KEXP  = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] ROUND = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [5:0] KEX_LAST = 6'(4 * (NR + 1) - 1);
    localparam logic [3:0] NR_W     = 4'(NR);

    generate
        if (!((NK == 4 && NR == 10) || (NK == 6 && NR == 12) || (NK == 8 && NR == 14))) begin : g_bad_params
            $error("aes_round_sequencer: illegal (NK,NR) pair");
        end
    endgenerate

    logic [2:0] state;
    logic [5:0] kex_cnt;
    logic [3:0] r;
    logic       keys_valid_q;
    logic       dec_q;

    // Handshake: start is a level sampled only in IDLE; abort is a level that
    // cancels KEXP/LOAD/ROUND on the next edge. No request is ever queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            kex_cnt      <= '0;
            r            <= '0;
            keys_valid_q <= 1'b0;
            dec_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        dec_q <= mode;
                        if (key_reuse && keys_valid_q) begin
                            state <= LOAD;
                        end else begin
                            keys_valid_q <= 1'b0;
                            kex_cnt      <= '0;
                            state        <= KEXP;
                        end
                    end
                end
                KEXP: begin
                    // keys_valid is still 0 here, so an abort leaves it cleared
                    if (abort) begin
                        state   <= IDLE;
                        kex_cnt <= '0;
                        r       <= '0;
                    end else if (kex_cnt == KEX_LAST) begin
                        keys_valid_q <= 1'b1;
                        kex_cnt      <= '0;
                        state        <= LOAD;
                    end else begin
                        kex_cnt <= kex_cnt + 6'd1;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state   <= IDLE;
                        kex_cnt <= '0;
                        r       <= '0;
                    end else begin
                        r     <= 4'd1;
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    if (abort) begin
                        state   <= IDLE;
                        kex_cnt <= '0;
                        r       <= '0;
                    end else if (r == NR_W) begin
                        r     <= '0;
                        state <= DONE;
                    end else begin
                        r <= r + 4'd1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    kex_cnt <= '0;
                    r       <= '0;
                end
                default: begin
                    state   <= IDLE;
                    kex_cnt <= '0;
                    r       <= '0;
                end
            endcase
        end
    end

    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
        kex_en   = (state == KEXP);
        kex_word = '0;
        ld_state = (state == LOAD);
        rnd_en   = (state == ROUND);
        rk_idx   = '0;
        last_rnd = 1'b0;
        if (state == KEXP) begin
            kex_word = kex_cnt;
        end
        if (state == LOAD) begin
            rk_idx = dec_q ? NR_W : 4'd0;
        end
        // Decrypt walks the schedule backwards: NR-1 down to 0
        if (state == ROUND) begin
            rk_idx   = dec_q ? (NR_W - r) : r;
            last_rnd = (r == NR_W);
        end
    end

    assign keys_valid = keys_valid_q;
    assign dec        = dec_q;
    assign dbg_state  = state;

endmodule
